max_pool_2x2: RTL and testbench

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

---
 rtl/cnn_pkg.sv | 34 +++
 rtl/fp_max2.sv | 15 +
 rtl/max_pool_2x2.sv | 102 ++++++++++
 tb/tb_max_pool_2x2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants and IEEE-754 single-precision max helper
package cnn_pkg;

   localparam int DATA_WIDTH = 32;
   localparam logic [DATA_WIDTH-1:0] FP_ZERO = 32'h0000_0000;

   // Ordered max of two floats; operand a is returned on a tie so that the
   // earlier-received pixel wins when callers pass the older value as a.
   // +0 and -0 compare equal; NaN is ordered purely by sign and magnitude.
   function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
      logic                  sa;
      logic                  sb;
      logic [DATA_WIDTH-2:0] ma;
      logic [DATA_WIDTH-2:0] mb;
      logic                  b_wins;
      sa = a[DATA_WIDTH-1];
      sb = b[DATA_WIDTH-1];
      ma = a[DATA_WIDTH-2:0];
      mb = b[DATA_WIDTH-2:0];
      b_wins = 1'b0;
      if ((ma == '0) && (mb == '0)) begin
         b_wins = 1'b0;
      end else if (sa != sb) begin
         b_wins = sa;
      end else if (!sa) begin
         b_wins = (mb > ma);
      end else begin
         b_wins = (mb < ma);
      end
      return b_wins ? b : a;
   endfunction

endpackage

// File: rtl/fp_max2.sv
// rtl/fp_max2.sv - combinational two-input float max, returns a on a tie
module fp_max2
   import cnn_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   // Pure combinational compare; all ordering rules live in the package helper
   always_comb begin
      y = fp_max(a, b);
   end

endmodule

// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - streaming 2x2 max pooling over a DxD float frame, optional MAXPOOL_RELU_EN clamp
module max_pool_2x2
   import cnn_pkg::*;
#(
   parameter int D          = 16,
   parameter int data_width = DATA_WIDTH
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [data_width-1:0] pxl_in,
   output logic [data_width-1:0] pxl_out,
   output logic                  valid_out
);

   localparam int HALF = D / 2;
   localparam int CW   = (D > 2) ? $clog2(D) : 1;
   localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0]         r_col;
   logic [CW-1:0]         r_row;
   logic [data_width-1:0] r_hold;
   logic [data_width-1:0] r_lb [HALF];

   logic [LBW-1:0]        w_lb_idx;
   logic [data_width-1:0] w_lb_rd;
   logic                  w_col_last;
   logic                  w_row_last;
   logic [data_width-1:0] w_m1_a;
   logic [data_width-1:0] w_m1_b;
   logic [data_width-1:0] w_m1;
   logic [data_width-1:0] w_m2;
   logic [data_width-1:0] w_pool;

   // Window position decode and operand steering for the shared first comparator.
   // Even rows: first comparator pairs the held pixel with the incoming one.
   // Odd rows: it pairs the line buffer (oldest) with the held pixel, and the
   // second comparator then folds in the incoming pixel, keeping arrival order.
   always_comb begin
      w_lb_idx   = LBW'(r_col >> 1);
      w_lb_rd    = r_lb[w_lb_idx];
      w_col_last = (r_col == CW'(D - 1));
      w_row_last = (r_row == CW'(D - 1));
      w_m1_a     = r_row[0] ? w_lb_rd : r_hold;
      w_m1_b     = r_row[0] ? r_hold  : pxl_in;
   end

   fp_max2 u_max_first (
      .a (w_m1_a),
      .b (w_m1_b),
      .y (w_m1)
   );

   fp_max2 u_max_second (
      .a (w_m1),
      .b (pxl_in),
      .y (w_m2)
   );

   // Optional ReLU clamp applied to the pooled value before it is registered
   always_comb begin
`ifdef MAXPOOL_RELU_EN
      w_pool = w_m2[data_width-1] ? FP_ZERO : w_m2;
`else
      w_pool = w_m2;
`endif
   end

   // Position counters, held pixel, line buffer and registered output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col     <= '0;
         r_row     <= '0;
         r_hold    <= '0;
         pxl_out   <= '0;
         valid_out <= 1'b0;
         for (int i = 0; i < HALF; i++) begin
            r_lb[i] <= '0;
         end
      end else begin
         valid_out <= 1'b0;
         if (valid_in) begin
            if (!r_col[0]) begin
               r_hold <= pxl_in;
            end else if (!r_row[0]) begin
               r_lb[w_lb_idx] <= w_m1;
            end else begin
               pxl_out   <= w_pool;
               valid_out <= 1'b1;
            end
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - scoreboard bench for max_pool_2x2 (D=16 ramp frames, D=2 window cases)
module tb_max_pool_2x2;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        v16   = 1'b0;
   logic [31:0] p16   = 32'h0;
   logic [31:0] o16;
   logic        vo16;
   logic        v2    = 1'b0;
   logic [31:0] p2    = 32'h0;
   logic [31:0] o2;
   logic        vo2;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          pulses16 = 0;
   int          pulses2  = 0;
   int          sum16    = 0;
   int          k18      = 0;
   int          first_cyc = 0;
   bit          first_arm = 1'b0;
   logic [31:0] exp16;
   logic [31:0] exp2;
   logic [31:0] q16 [$];
   logic [31:0] q2  [$];
   int          avg_q [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   max_pool_2x2 #(.D(16), .data_width(32)) u_dut16 (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (v16),
      .pxl_in    (p16),
      .pxl_out   (o16),
      .valid_out (vo16)
   );

   max_pool_2x2 #(.D(2), .data_width(32)) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (v2),
      .pxl_in    (p2),
      .pxl_out   (o2),
      .valid_out (vo2)
   );

   function automatic logic [31:0] i2f(input int n);
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 31; i++) if (n[i]) p = i;
      m = 32'(n) << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   function automatic int f2i(input logic [31:0] b);
      int          e;
      logic [31:0] m;
      if (b[30:0] == 31'h0) return 0;
      e = int'(b[30:23]) - 127;
      if (e < 0 || e > 23) return -1;
      m = {8'h0, 1'b1, b[22:0]};
      return int'(m >> (23 - e));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Output monitor: reset-state checks and scoreboard pops, sampled on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_vout16", {31'h0, vo16}, 32'h0);
         chk("rst_pout16", o16, 32'h0);
         chk("rst_vout2", {31'h0, vo2}, 32'h0);
      end else begin
         if (vo16) begin
            if (q16.size() == 0) begin
               chk("unexpected_pulse16", 32'(q16.size()), 32'd1);
            end else begin
               exp16 = q16.pop_front();
               chk("pxl16", o16, exp16);
            end
            pulses16++;
            sum16 += f2i(o16);
            if (pulses16 % 64 == 0) begin
               avg_q.push_back(sum16 / 64);
               sum16 = 0;
            end
            if (first_arm) begin
               first_cyc = cyc;
               first_arm = 1'b0;
            end
         end
         if (vo2) begin
            if (q2.size() == 0) begin
               chk("unexpected_pulse2", 32'(q2.size()), 32'd1);
            end else begin
               exp2 = q2.pop_front();
               chk("pxl2", o2, exp2);
            end
            pulses2++;
         end
      end
   end

   task automatic send16(input int r, input int c);
      @(posedge clk); #1;
      v16 = 1'b1;
      p16 = i2f(r * 16 + c);
      if (r == 1 && c == 1) k18 = cyc;
      if (r[0] && c[0]) q16.push_back(i2f(r * 16 + c));
   endtask

   task automatic idle16();
      @(posedge clk); #1;
      v16 = 1'b0;
   endtask

   task automatic ramp16(input bit gaps);
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            send16(r, c);
            if (gaps) idle16();
         end
      end
   endtask

   task automatic drain16(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (q16.size() == 0) break;
         @(posedge clk);
      end
      chk(tag, 32'(q16.size()), 32'd0);
   endtask

   task automatic send2(input logic [31:0] px, input bit last, input logic [31:0] expv);
      @(posedge clk); #1;
      v2 = 1'b1;
      p2 = px;
      if (last) q2.push_back(expv);
   endtask

   task automatic window2(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d,
                          input logic [31:0] expv);
      send2(a, 1'b0, 32'h0);
      send2(b, 1'b0, 32'h0);
      send2(c, 1'b0, 32'h0);
      send2(d, 1'b1, expv);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] neg_exp;
      logic [31:0] tie_exp;
`ifdef MAXPOOL_RELU_EN
      neg_exp = 32'h0000_0000;
      tie_exp = 32'h0000_0000;
`else
      neg_exp = 32'hBF00_0000;
      tie_exp = 32'h8000_0000;
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Continuous ramp frame: 64 pulses, first one a cycle after the 18th pixel
      pulses16  = 0;
      sum16     = 0;
      first_arm = 1'b1;
      ramp16(1'b0);
      idle16();
      drain16("drain_ramp");
      chk("pulses_ramp", 32'(pulses16), 32'd64);
      chk("first_latency", 32'(first_cyc - k18), 32'd1);
      idle16();
      idle16();
      chk("hold_vout", {31'h0, vo16}, 32'h0);
      chk("hold_pout", o16, i2f(255));

      // D=2 windows, back to back with no idle between frames
      pulses2 = 0;
      window2(32'hBF80_0000, 32'hC040_0000, 32'hBF00_0000, 32'hC000_0000, neg_exp);
      window2(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
      window2(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, tie_exp);
      window2(32'h3F80_0000, 32'h4000_0000, 32'hC080_0000, 32'h3FC0_0000, 32'h4000_0000);
      @(posedge clk); #1 v2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (q2.size() == 0) break;
         @(posedge clk);
      end
      chk("drain_d2", 32'(q2.size()), 32'd0);
      chk("pulses_d2", 32'(pulses2), 32'd4);

      // Ramp with valid_in toggling every cycle
      pulses16 = 0;
      sum16    = 0;
      ramp16(1'b1);
      idle16();
      drain16("drain_gaps");
      chk("pulses_gaps", 32'(pulses16), 32'd64);

      // Reset after 40 pixels, then a clean frame
      pulses16 = 0;
      for (int i = 0; i < 40; i++) send16(i / 16, i % 16);
      idle16();
      drain16("drain_partial");
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      pulses16 = 0;
      sum16    = 0;
      ramp16(1'b0);
      idle16();
      drain16("drain_after_reset");
      chk("pulses_after_reset", 32'(pulses16), 32'd64);

      // Two back-to-back frames, each averaging to 136
      pulses16 = 0;
      sum16    = 0;
      avg_q.delete();
      ramp16(1'b0);
      ramp16(1'b0);
      idle16();
      drain16("drain_b2b");
      chk("pulses_b2b", 32'(pulses16), 32'd128);
      chk("avg_count", 32'(avg_q.size()), 32'd2);
      while (avg_q.size() > 0) chk("avg_value", 32'(avg_q.pop_front()), 32'd136);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
